// File: rtl/apb_arb_pkg.sv
// Shared encodings for the two-requester APB arbiter: FSM states and requester indices.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_t;

  localparam logic M_IFETCH = 1'b0;
  localparam logic M_LSU    = 1'b1;

endpackage

// File: rtl/apb_arb_pick.sv
// Combinational winner selection between instruction fetch (m0) and load/store (m1).
// With APB_ARB_RR_EN defined, contention alternates via 'last'; otherwise m1 has fixed priority.
module apb_arb_pick
  import apb_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef APB_ARB_RR_EN
  input  logic       last,
`endif
  output logic       grant
);

  always_comb begin
    grant = M_IFETCH;
    case (req)
      2'b10: grant = M_LSU;
      2'b11: begin
`ifdef APB_ARB_RR_EN
        grant = ~last;
`else
        grant = M_LSU;
`endif
      end
      default: grant = M_IFETCH;
    endcase
  end

endmodule

// File: rtl/apb_arbiter.sv
// Two-master to one-slave APB arbiter with a registered slave-side transfer.
// Optional round-robin contention resolution is enabled by defining APB_ARB_RR_EN.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  pclk,
  input  logic                  presetn,

  input  logic [ADDR_WIDTH-1:0] m0_paddr,
  input  logic [DATA_WIDTH-1:0] m0_pdata,
  input  logic                  m0_psel,
  input  logic                  m0_pwrite,
  input  logic [3:0]            m0_pstb,
  output logic [DATA_WIDTH-1:0] m0_prdata,
  output logic                  m0_pready,
  output logic                  m0_perr,

  input  logic [ADDR_WIDTH-1:0] m1_paddr,
  input  logic [DATA_WIDTH-1:0] m1_pdata,
  input  logic                  m1_psel,
  input  logic                  m1_pwrite,
  input  logic [3:0]            m1_pstb,
  output logic [DATA_WIDTH-1:0] m1_prdata,
  output logic                  m1_pready,
  output logic                  m1_perr,

  output logic [ADDR_WIDTH-1:0] s_paddr,
  output logic [DATA_WIDTH-1:0] s_pdata,
  output logic                  s_pwrite,
  output logic [3:0]            s_pstb,
  output logic                  s_psel,
  output logic                  s_penable,
  input  logic [DATA_WIDTH-1:0] s_prdata,
  input  logic                  s_pready,
  input  logic                  s_perr
);

  arb_state_t state, state_next;
  logic       grant;
  logic       pick_grant;
  logic [1:0] req;
  logic       start;
  logic       granted_psel;

  assign req   = {m1_psel, m0_psel};
  assign start = (state == IDLE) && (|req);

`ifdef APB_ARB_RR_EN
  logic last;

  apb_arb_pick u_pick (
    .req   (req),
    .last  (last),
    .grant (pick_grant)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      last <= M_IFETCH;
    end else if (start) begin
      last <= pick_grant;
    end
  end
`else
  apb_arb_pick u_pick (
    .req   (req),
    .grant (pick_grant)
  );
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // s_pready ends ACCESS regardless of s_perr or whether the requester still wants the data.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (s_pready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The slave-side transfer is captured once at grant and held through completion.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      grant    <= M_IFETCH;
      s_paddr  <= '0;
      s_pdata  <= '0;
      s_pwrite <= 1'b0;
      s_pstb   <= '0;
    end else if (start) begin
      grant    <= pick_grant;
      s_paddr  <= pick_grant ? m1_paddr  : m0_paddr;
      s_pdata  <= pick_grant ? m1_pdata  : m0_pdata;
      s_pwrite <= pick_grant ? m1_pwrite : m0_pwrite;
      s_pstb   <= pick_grant ? m1_pstb   : m0_pstb;
    end
  end

  assign granted_psel = grant ? m1_psel : m0_psel;

  // A requester that withdrew psel mid-transfer gets no completion; the response is dropped.
  always_comb begin
    s_psel    = (state == SETUP) || (state == ACCESS);
    s_penable = (state == ACCESS);
    m0_prdata = s_prdata;
    m1_prdata = s_prdata;
    m0_pready = 1'b0;
    m1_pready = 1'b0;
    m0_perr   = 1'b0;
    m1_perr   = 1'b0;
    if ((state == ACCESS) && s_pready && granted_psel) begin
      if (grant == M_LSU) begin
        m1_pready = 1'b1;
        m1_perr   = s_perr;
      end else begin
        m0_pready = 1'b1;
        m0_perr   = s_perr;
      end
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter with a small word memory on the slave side.
// Expectations follow APB_ARB_RR_EN when the bench is built with it.
module tb_apb_arbiter;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [31:0] m0_paddr, m0_pdata, m1_paddr, m1_pdata;
  logic        m0_psel, m0_pwrite, m1_psel, m1_pwrite;
  logic [3:0]  m0_pstb, m1_pstb;
  logic [31:0] m0_prdata, m1_prdata;
  logic        m0_pready, m0_perr, m1_pready, m1_perr;
  logic [31:0] s_paddr, s_pdata, s_prdata;
  logic        s_pwrite, s_psel, s_penable, s_pready, s_perr;
  logic [3:0]  s_pstb;

  logic        ready_en;
  logic        err_en;
  logic [31:0] mem [0:63];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 pclk = ~pclk;

  apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .m0_paddr  (m0_paddr),
    .m0_pdata  (m0_pdata),
    .m0_psel   (m0_psel),
    .m0_pwrite (m0_pwrite),
    .m0_pstb   (m0_pstb),
    .m0_prdata (m0_prdata),
    .m0_pready (m0_pready),
    .m0_perr   (m0_perr),
    .m1_paddr  (m1_paddr),
    .m1_pdata  (m1_pdata),
    .m1_psel   (m1_psel),
    .m1_pwrite (m1_pwrite),
    .m1_pstb   (m1_pstb),
    .m1_prdata (m1_prdata),
    .m1_pready (m1_pready),
    .m1_perr   (m1_perr),
    .s_paddr   (s_paddr),
    .s_pdata   (s_pdata),
    .s_pwrite  (s_pwrite),
    .s_pstb    (s_pstb),
    .s_psel    (s_psel),
    .s_penable (s_penable),
    .s_prdata  (s_prdata),
    .s_pready  (s_pready),
    .s_perr    (s_perr)
  );

  // Zero-wait memory unless ready_en is held low to stretch ACCESS.
  assign s_pready = s_penable && ready_en;
  assign s_perr   = s_penable && err_en;
  assign s_prdata = mem[s_paddr[7:2]];

  always @(posedge pclk) begin
    if (s_psel && s_penable && s_pready && s_pwrite) begin
      for (int b = 0; b < 4; b++) begin
        if (s_pstb[b]) mem[s_paddr[7:2]][8*b +: 8] <= s_pdata[8*b +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    logic        first_m1;
    logic        exp_m1;
    logic [31:0] first_addr, second_addr, first_data;

`ifdef APB_ARB_RR_EN
    first_m1 = 1'b0;
`else
    first_m1 = 1'b1;
`endif
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'hAABBCCDD;
    presetn  = 1'b0;
    ready_en = 1'b1;
    err_en   = 1'b0;
    m0_paddr = '0; m0_pdata = '0; m0_psel = 1'b0; m0_pwrite = 1'b0; m0_pstb = '0;
    m1_paddr = '0; m1_pdata = '0; m1_psel = 1'b0; m1_pwrite = 1'b0; m1_pstb = '0;

    repeat (2) @(negedge pclk);
    check_output("rst_psel", s_psel, 0);
    check_output("rst_penable", s_penable, 0);
    check_output("rst_paddr", s_paddr, 0);
    check_output("rst_pwrite", s_pwrite, 0);
    check_output("rst_m0_pready", m0_pready, 0);
    check_output("rst_m1_pready", m1_pready, 0);
    presetn = 1'b1;
    tick();
    check_output("idle_no_req", s_psel, 0);

    // m0 read alone
    m0_paddr = 32'h100; m0_pwrite = 1'b0; m0_pstb = 4'hF; m0_psel = 1'b1;
    tick();
    check_output("rd_setup_psel", s_psel, 1);
    check_output("rd_setup_penable", s_penable, 0);
    check_output("rd_setup_paddr", s_paddr, 32'h100);
    tick();
    check_output("rd_access_penable", s_penable, 1);
    check_output("rd_m0_pready", m0_pready, 1);
    check_output("rd_m0_prdata", m0_prdata, 32'hDEADBEEF);
    check_output("rd_m1_pready", m1_pready, 0);
    tick();
    check_output("rd_back_idle", s_psel, 0);
    m0_psel = 1'b0;
    tick();
    check_output("rd_stay_idle", s_psel, 0);

    // m1 partial write with one wait state
    m1_paddr = 32'h204; m1_pdata = 32'h11223344; m1_pwrite = 1'b1; m1_pstb = 4'b0011; m1_psel = 1'b1;
    ready_en = 1'b0;
    tick();
    check_output("wr_setup_pdata", s_pdata, 32'h11223344);
    check_output("wr_setup_pstb", s_pstb, 4'b0011);
    check_output("wr_setup_pwrite", s_pwrite, 1);
    tick();
    check_output("wr_wait_pdata", s_pdata, 32'h11223344);
    check_output("wr_wait_pstb", s_pstb, 4'b0011);
    check_output("wr_wait_m1_pready", m1_pready, 0);
    check_output("wr_wait_penable", s_penable, 1);
    ready_en = 1'b1;
    #1;
    check_output("wr_m1_pready", m1_pready, 1);
    tick();
    check_output("wr_mem_word", mem[1], 32'hAABB3344);
    check_output("wr_back_idle", s_psel, 0);
    m1_psel = 1'b0; m1_pwrite = 1'b0; m1_pstb = 4'hF;
    tick();

    // simultaneous requests; second transfer also returns an error
    first_addr  = first_m1 ? 32'h204 : 32'h100;
    second_addr = first_m1 ? 32'h100 : 32'h204;
    first_data  = first_m1 ? 32'hAABB3344 : 32'hDEADBEEF;
    m0_paddr = 32'h100; m1_paddr = 32'h204;
    m0_psel = 1'b1; m1_psel = 1'b1;
    tick();
    check_output("cont_first_paddr", s_paddr, first_addr);
    tick();
    check_output("cont_first_m1_pready", m1_pready, first_m1);
    check_output("cont_first_m0_pready", m0_pready, !first_m1);
    check_output("cont_first_prdata", first_m1 ? m1_prdata : m0_prdata, first_data);
    tick();
    check_output("cont_idle_gap", s_psel, 0);
    if (first_m1) m1_psel = 1'b0; else m0_psel = 1'b0;
    tick();
    check_output("cont_second_paddr", s_paddr, second_addr);
    err_en = 1'b1;
    tick();
    check_output("cont_second_m1_pready", m1_pready, !first_m1);
    check_output("cont_second_m0_pready", m0_pready, first_m1);
    check_output("cont_second_m1_perr", m1_perr, !first_m1);
    check_output("cont_second_m0_perr", m0_perr, first_m1);
    tick();
    check_output("cont_err_back_idle", s_psel, 0);
    m0_psel = 1'b0; m1_psel = 1'b0; err_en = 1'b0;
    tick();

    // m0 abandons the request during ACCESS
    m0_psel = 1'b1;
    tick();
    ready_en = 1'b0;
    tick();
    m0_psel = 1'b0;
    ready_en = 1'b1;
    #1;
    check_output("drop_m0_pready", m0_pready, 0);
    check_output("drop_m1_pready", m1_pready, 0);
    check_output("drop_penable", s_penable, 1);
    tick();
    check_output("drop_back_idle", s_psel, 0);
    tick();
    check_output("drop_stay_idle", s_psel, 0);

    // reset pulse in ACCESS, then a normal transfer
    m0_psel = 1'b1;
    ready_en = 1'b0;
    tick();
    tick();
    check_output("rstmid_access", s_penable, 1);
    presetn = 1'b0;
    ready_en = 1'b1;
    #1;
    check_output("rstmid_psel", s_psel, 0);
    check_output("rstmid_penable", s_penable, 0);
    check_output("rstmid_m0_pready", m0_pready, 0);
    check_output("rstmid_paddr", s_paddr, 0);
    #1;
    presetn = 1'b1;
    tick();
    check_output("rstmid_restart_psel", s_psel, 1);
    check_output("rstmid_restart_paddr", s_paddr, 32'h100);
    tick();
    check_output("rstmid_m0_pready_after", m0_pready, 1);
    check_output("rstmid_m0_prdata", m0_prdata, 32'hDEADBEEF);
    tick();
    m0_psel = 1'b0;
    check_output("rstmid_back_idle", s_psel, 0);
    tick();

    // both requesters hold psel across eight transfers
    m0_psel = 1'b1; m1_psel = 1'b1;
    for (int i = 0; i < 8; i++) begin
`ifdef APB_ARB_RR_EN
      exp_m1 = (i % 2 == 0);
`else
      exp_m1 = 1'b1;
`endif
      tick();
      check_output("hold_paddr", s_paddr, exp_m1 ? 32'h204 : 32'h100);
      tick();
      check_output("hold_m1_pready", m1_pready, exp_m1);
      check_output("hold_m0_pready", m0_pready, !exp_m1);
      tick();
      check_output("hold_idle_gap", s_psel, 0);
    end
    m0_psel = 1'b0; m1_psel = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
